// File: rtl/debounce_pkg.sv
// Shared constants and width helper for the multi-channel button debouncer.
package debounce_pkg;

    localparam int DEB_CHANNELS_DEF      = 4;
    localparam int DEB_STABLE_CYCLES_DEF = 5;
    localparam int DEB_HOLD_CYCLES_DEF   = 50_000_000;

    // Bits needed to count from 0 up to max_val inclusive (never less than 1).
    function automatic int deb_cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/debounce_multi_if.sv
// Button bus between the board-input boundary and the debouncer.
// master: side that drives the raw buttons and consumes the clean signals.
// slave : the debouncer itself.
interface debounce_multi_if
    import debounce_pkg::*;
#(
    parameter int CHANNELS = DEB_CHANNELS_DEF
);

    logic [CHANNELS-1:0] btn_in;
    logic [CHANNELS-1:0] btn_level;
    logic [CHANNELS-1:0] btn_press;
    logic [CHANNELS-1:0] btn_release;
    logic [CHANNELS-1:0] btn_hold;

    modport master (
        output btn_in,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_hold
    );

    modport slave (
        input  btn_in,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_hold
    );

endinterface

// File: rtl/debounce_channel.sv
// One debouncer channel: 2-flop synchroniser, stability counter, registered
// level, press/release strobes. The long-press counter and strobe are only
// built when DEBOUNCE_HOLD_EN is defined; otherwise hold_o is tied low.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEB_STABLE_CYCLES_DEF,
    parameter int HOLD_CYCLES   = DEB_HOLD_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic hold_o
);

    localparam int             CNT_W    = deb_cnt_w(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    // sync_q[0] is the first (metastability) flop, sync_q[1] the clean sample.
    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             rel_q,   rel_d;
    logic             differ;
    logic             accept;

    // Two-flop synchroniser; only the second stage is used downstream.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync_q <= '0;
        else        sync_q <= {sync_q[0], btn_i};
    end

    // Count consecutive disagreeing samples; accept on the last one so the
    // counter never passes STABLE_CYCLES-1 and cannot wrap.
    always_comb begin
        differ  = sync_q[1] ^ level_q;
        accept  = differ && (cnt_q == CNT_LAST);
        cnt_d   = (!differ || accept) ? '0 : cnt_q + CNT_W'(1);
        level_d = accept ? sync_q[1] : level_q;
        press_d = accept &  sync_q[1];
        rel_d   = accept & ~sync_q[1];
    end

    // Level, counter and edge strobes; strobes land with the level update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = rel_q;

`ifdef DEBOUNCE_HOLD_EN
    localparam int               HOLD_W    = deb_cnt_w(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);

    logic [HOLD_W-1:0] hcnt_q, hcnt_d;
    logic              hold_q, hold_d;

    // Saturating high-time counter; strobe on the step that reaches HOLD_CYCLES.
    always_comb begin
        hcnt_d = hcnt_q;
        if (!level_q)              hcnt_d = '0;
        else if (hcnt_q != HOLD_MAX) hcnt_d = hcnt_q + HOLD_W'(1);
        hold_d = level_q && (hcnt_q == HOLD_LAST);
    end

    // Hold counter and long-press strobe registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hcnt_q <= '0;
            hold_q <= 1'b0;
        end else begin
            hcnt_q <= hcnt_d;
            hold_q <= hold_d;
        end
    end

    assign hold_o = hold_q;
`else
    assign hold_o = 1'b0;
`endif

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel button debouncer top. Each channel is an independent
// debounce_channel; this level only fans the bus out and back in.
// Optional long-press strobe: define DEBOUNCE_HOLD_EN.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int CHANNELS      = DEB_CHANNELS_DEF,
    parameter int STABLE_CYCLES = DEB_STABLE_CYCLES_DEF,
    parameter int HOLD_CYCLES   = DEB_HOLD_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    debounce_multi_if.slave  bus
);

    logic [CHANNELS-1:0] level;
    logic [CHANNELS-1:0] press;
    logic [CHANNELS-1:0] rel;
    logic [CHANNELS-1:0] hold;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .HOLD_CYCLES   (HOLD_CYCLES)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .btn_i     (bus.btn_in[i]),
            .level_o   (level[i]),
            .press_o   (press[i]),
            .release_o (rel[i]),
            .hold_o    (hold[i])
        );
    end

    assign bus.btn_level   = level;
    assign bus.btn_press   = press;
    assign bus.btn_release = rel;
    assign bus.btn_hold    = hold;

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi: latency, glitch rejection, simultaneous
// edges, reset mid-count and the long-press strobe (when DEBOUNCE_HOLD_EN).
module tb_debounce_multi;
    import debounce_pkg::*;

    localparam int CH = 4;
    localparam int ST = 5;
    localparam int HC = 10;

`ifdef DEBOUNCE_HOLD_EN
    localparam logic [3:0] HOLD_EXP = 4'b0100;
`else
    localparam logic [3:0] HOLD_EXP = 4'b0000;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    debounce_multi_if #(.CHANNELS(CH)) bus ();

    debounce_multi #(
        .CHANNELS      (CH),
        .STABLE_CYCLES (ST),
        .HOLD_CYCLES   (HC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Run n cycles, OR-ing together every strobe seen.
    task automatic accum(input int n, output logic [3:0] p, output logic [3:0] r,
                         output logic [3:0] h);
        p = '0; r = '0; h = '0;
        repeat (n) begin
            @(posedge clk);
            #1;
            p = p | bus.btn_press;
            r = r | bus.btn_release;
            h = h | bus.btn_hold;
        end
    endtask

    // Press and release must never coincide on a channel.
    logic [3:0] ovl = '0;
    always @(negedge clk) ovl = ovl | (bus.btn_press & bus.btn_release);

    logic [3:0] pa, ra, ha;

    initial begin
        reset      = 1'b1;
        bus.btn_in = 4'b0000;
        #2 reset   = 1'b0;
        step(3);
        chk("rst_level",   {28'd0, bus.btn_level}, 32'h0);
        chk("rst_strobes", {20'd0, bus.btn_press, bus.btn_release, bus.btn_hold}, 32'h0);
        reset = 1'b1;
        accum(20, pa, ra, ha);
        chk("idle_level", {28'd0, bus.btn_level}, 32'h0);
        chk("idle_strobes", {20'd0, pa, ra, ha}, 32'h0);

        // Channel 0 press: level on the 7th edge after the change.
        bus.btn_in = 4'b0001;
        step(6);
        chk("ch0_pre_level", {28'd0, bus.btn_level}, 32'h0);
        chk("ch0_pre_press", {28'd0, bus.btn_press}, 32'h0);
        step(1);
        chk("ch0_level",   {28'd0, bus.btn_level},   32'h1);
        chk("ch0_press",   {28'd0, bus.btn_press},   32'h1);
        chk("ch0_release", {28'd0, bus.btn_release}, 32'h0);
        step(1);
        chk("ch0_press_end", {28'd0, bus.btn_press}, 32'h0);

        // Channel 1: 4-cycle glitch is rejected.
        bus.btn_in = 4'b0011;
        step(4);
        bus.btn_in = 4'b0001;
        accum(12, pa, ra, ha);
        chk("glitch_press", {28'd0, pa}, 32'h0);
        chk("glitch_level", {28'd0, bus.btn_level}, 32'h1);

        // Channel 1: 5-cycle pulse is accepted.
        bus.btn_in = 4'b0011;
        step(5);
        bus.btn_in = 4'b0001;
        step(1);
        chk("ch1_pre_level", {28'd0, bus.btn_level}, 32'h1);
        step(1);
        chk("ch1_level", {28'd0, bus.btn_level}, 32'h3);
        chk("ch1_press", {28'd0, bus.btn_press}, 32'h2);
        step(1);
        chk("ch1_press_end", {28'd0, bus.btn_press}, 32'h0);

        // Drop everything: both active channels release.
        bus.btn_in = 4'b0000;
        accum(10, pa, ra, ha);
        chk("drop_release", {28'd0, ra}, 32'h3);
        chk("drop_press",   {28'd0, pa}, 32'h0);
        chk("drop_level",   {28'd0, bus.btn_level}, 32'h0);

        // All channels together.
        bus.btn_in = 4'b1111;
        step(6);
        chk("all_pre_level", {28'd0, bus.btn_level}, 32'h0);
        step(1);
        chk("all_press",   {28'd0, bus.btn_press},   32'hf);
        chk("all_rel_low", {28'd0, bus.btn_release}, 32'h0);
        chk("all_level",   {28'd0, bus.btn_level},   32'hf);
        step(1);
        chk("all_press_end", {28'd0, bus.btn_press}, 32'h0);
        bus.btn_in = 4'b0000;
        step(6);
        chk("all_rel_pre", {28'd0, bus.btn_release}, 32'h0);
        step(1);
        chk("all_release",   {28'd0, bus.btn_release}, 32'hf);
        chk("all_press_low", {28'd0, bus.btn_press},   32'h0);
        chk("all_level_low", {28'd0, bus.btn_level},   32'h0);
        step(1);
        chk("all_release_end", {28'd0, bus.btn_release}, 32'h0);

        // Reset mid-count with inputs held high.
        bus.btn_in = 4'b0100;
        step(8);
        chk("ch2_level_set", {28'd0, bus.btn_level}, 32'h4);
        bus.btn_in = 4'b0101;
        step(5);
        reset = 1'b0;
        #1;
        chk("midrst_level",   {28'd0, bus.btn_level}, 32'h0);
        chk("midrst_strobes", {20'd0, bus.btn_press, bus.btn_release, bus.btn_hold}, 32'h0);
        step(2);
        reset = 1'b1;
        step(6);
        chk("postrst_pre_press", {28'd0, bus.btn_press}, 32'h0);
        chk("postrst_pre_level", {28'd0, bus.btn_level}, 32'h0);
        step(1);
        chk("postrst_press", {28'd0, bus.btn_press}, 32'h5);
        chk("postrst_level", {28'd0, bus.btn_level}, 32'h5);
        step(1);

        // Long press on channel 2.
        bus.btn_in = 4'b0000;
        step(10);
        bus.btn_in = 4'b0100;
        step(7);
        chk("hold_level", {28'd0, bus.btn_level}, 32'h4);
        step(9);
        chk("hold_early", {28'd0, bus.btn_hold}, 32'h0);
        step(1);
        chk("hold_pulse", {28'd0, bus.btn_hold}, {28'd0, HOLD_EXP});
        step(1);
        chk("hold_end", {28'd0, bus.btn_hold}, 32'h0);
        accum(20, pa, ra, ha);
        chk("hold_once", {28'd0, ha}, 32'h0);

        // Release and press again re-arms the long-press strobe.
        bus.btn_in = 4'b0000;
        step(10);
        bus.btn_in = 4'b0100;
        step(17);
        chk("rearm_pulse", {28'd0, bus.btn_hold}, {28'd0, HOLD_EXP});
        step(1);
        chk("rearm_end", {28'd0, bus.btn_hold}, 32'h0);

        chk("no_overlap", {28'd0, ovl}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
